mesi_isc_cbus_snoop_resp: RTL

MESI_ISC_CBUS_SNOOP_RESP -- requirements
Module: mesi_isc_cbus_snoop_resp

---
 rtl/mesi_isc_cbus_snoop_resp.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mesi_isc_cbus_snoop_resp.sv
// Snoop responder for one CPU on the MESI coherence bus: tracks direct-mapped line states and acks bus commands.
// Optional snoop hit/miss counters are enabled with the MESI_ISC_SNOOP_STATS_EN macro.
module mesi_isc_cbus_snoop_resp #(
   parameter int CBUS_CMD_WIDTH = 3,
   parameter int ADDR_WIDTH     = 32,
   parameter int LINE_NUM       = 4,
   parameter int LINE_NUM_LOG2  = 2,
   parameter int WB_LATENCY     = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
   input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
   output logic                      cbus_ack_o,
   output logic                      en_wr_o,
   output logic                      en_rd_o,
   output logic                      wb_busy_o,
`ifdef MESI_ISC_SNOOP_STATS_EN
   output logic [15:0]               snoop_hit_cnt_o,
   output logic [15:0]               snoop_miss_cnt_o,
`endif
   input  logic                      fill_i,
   input  logic [ADDR_WIDTH-1:0]     fill_addr_i,
   input  logic [1:0]                fill_state_i,
   output logic                      fill_ready_o
);

   localparam int TAG_W = ADDR_WIDTH - LINE_NUM_LOG2;
   localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
   localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
   localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
   localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);
   localparam logic [1:0] LS_I = 2'd0;
   localparam logic [1:0] LS_S = 2'd1;
   localparam logic [1:0] LS_E = 2'd2;
   localparam logic [1:0] LS_M = 2'd3;

   typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_WB, ST_ACK, ST_WAIT_NOP} state_t;

   state_t                    state_q;
   logic [CBUS_CMD_WIDTH-1:0] cmd_q;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [3:0]                wb_cnt_q;
   logic                      ack_q, en_wr_q, en_rd_q, wb_busy_q;
   logic [1:0]                line_st_q  [LINE_NUM];
   logic [TAG_W-1:0]          line_tag_q [LINE_NUM];
`ifdef MESI_ISC_SNOOP_STATS_EN
   logic [15:0]               hit_cnt_q, miss_cnt_q;
`endif

   logic [LINE_NUM_LOG2-1:0]  lk_idx_d, fill_idx_d;
   logic                      lk_hit_d, lk_m_d, in_snoop_d, in_en_d, in_nop_d, cmd_snoop_d;

   // Lookup is done against the captured address; lines cannot change between LOOKUP and ACK
   // because fills are only accepted in IDLE, so the same result is reused for the ACK update.
   always_comb begin
      lk_idx_d    = addr_q[LINE_NUM_LOG2-1:0];
      fill_idx_d  = fill_addr_i[LINE_NUM_LOG2-1:0];
      lk_hit_d    = (line_st_q[lk_idx_d] != LS_I) &&
                    (line_tag_q[lk_idx_d] == addr_q[ADDR_WIDTH-1:LINE_NUM_LOG2]);
      lk_m_d      = lk_hit_d && (line_st_q[lk_idx_d] == LS_M);
      in_snoop_d  = (cbus_cmd_i == CMD_WR_SNOOP) || (cbus_cmd_i == CMD_RD_SNOOP);
      in_en_d     = (cbus_cmd_i == CMD_EN_WR) || (cbus_cmd_i == CMD_EN_RD);
      in_nop_d    = !in_snoop_d && !in_en_d;
      cmd_snoop_d = (cmd_q == CMD_WR_SNOOP) || (cmd_q == CMD_RD_SNOOP);
   end

   assign fill_ready_o = (state_q == ST_IDLE) && in_nop_d;
   assign cbus_ack_o   = ack_q;
   assign en_wr_o      = en_wr_q;
   assign en_rd_o      = en_rd_q;
   assign wb_busy_o    = wb_busy_q;
`ifdef MESI_ISC_SNOOP_STATS_EN
   assign snoop_hit_cnt_o  = hit_cnt_q;
   assign snoop_miss_cnt_o = miss_cnt_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wb_cnt_q  <= 4'd0;
         ack_q     <= 1'b0;
         en_wr_q   <= 1'b0;
         en_rd_q   <= 1'b0;
         wb_busy_q <= 1'b0;
         for (int i = 0; i < LINE_NUM; i++) begin
            line_st_q[i]  <= LS_I;
            line_tag_q[i] <= '0;
         end
`ifdef MESI_ISC_SNOOP_STATS_EN
         hit_cnt_q  <= 16'd0;
         miss_cnt_q <= 16'd0;
`endif
      end else begin
         ack_q   <= 1'b0;
         en_wr_q <= 1'b0;
         en_rd_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (in_snoop_d) begin
                  addr_q  <= cbus_addr_i;
                  cmd_q   <= cbus_cmd_i;
                  state_q <= ST_LOOKUP;
               end else if (in_en_d) begin
                  cmd_q   <= cbus_cmd_i;
                  state_q <= ST_ACK;
                  ack_q   <= 1'b1;
                  en_wr_q <= (cbus_cmd_i == CMD_EN_WR);
                  en_rd_q <= (cbus_cmd_i == CMD_EN_RD);
               end else if (fill_i) begin
                  line_st_q[fill_idx_d]  <= fill_state_i;
                  line_tag_q[fill_idx_d] <= fill_addr_i[ADDR_WIDTH-1:LINE_NUM_LOG2];
               end
            end
            ST_LOOKUP: begin
               if (lk_m_d) begin
                  state_q   <= ST_WB;
                  wb_cnt_q  <= 4'(WB_LATENCY);
                  wb_busy_q <= 1'b1;
               end else begin
                  state_q <= ST_ACK;
                  ack_q   <= 1'b1;
               end
            end
            ST_WB: begin
               if (wb_cnt_q == 4'd1) begin
                  state_q   <= ST_ACK;
                  wb_cnt_q  <= 4'd0;
                  wb_busy_q <= 1'b0;
                  ack_q     <= 1'b1;
               end else begin
                  wb_cnt_q <= wb_cnt_q - 4'd1;
               end
            end
            ST_ACK: begin
               state_q <= ST_WAIT_NOP;
               if (cmd_snoop_d && lk_hit_d) begin
                  if (cmd_q == CMD_WR_SNOOP)
                     line_st_q[lk_idx_d] <= LS_I;
                  else if (line_st_q[lk_idx_d] == LS_M || line_st_q[lk_idx_d] == LS_E)
                     line_st_q[lk_idx_d] <= LS_S;
               end
`ifdef MESI_ISC_SNOOP_STATS_EN
               if (cmd_snoop_d && lk_hit_d)  hit_cnt_q  <= hit_cnt_q + 16'd1;
               if (cmd_snoop_d && !lk_hit_d) miss_cnt_q <= miss_cnt_q + 16'd1;
`endif
            end
            ST_WAIT_NOP: begin
               if (in_nop_d) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
